// File: rtl/slave_read_mem_burst_if.sv
// AXI-style read address / read data channel bundle shared by the
// burst slave and whatever master drives it.
interface slave_read_mem_burst_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
);
  // Handshakes: a transfer happens on a rising clock edge where VALID and
  // READY are both high; the source holds payload stable while VALID is
  // high and READY is low, and never waits on READY to raise VALID.
  logic [ID_W-1:0]   ARID;
  logic [ADDR_W-1:0] ARADDR;
  logic [LEN_W-1:0]  ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic              ARVALID;
  logic              ARREADY;

  logic [ID_W-1:0]   RID;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/slave_read_mem_burst.sv
// Read-burst slave: accepts one AR request at a time, reads each beat from a
// fixed-latency memory and returns it on the R channel (FIXED/INCR/WRAP).
module slave_read_mem_burst #(
  parameter int ID_W    = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 4,
  parameter int MEM_LAT = 2
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  slave_read_mem_burst_if.slave bus,
  input  logic                ar_block,
  output logic                mem_cs,
  output logic [ADDR_W-1:0]   address_out,
  input  logic [DATA_W-1:0]   data_in,
  output logic [1:0]          dbg_state
);
  localparam int         MAX_SIZE = $clog2(DATA_W / 8);
  localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

  state_t              state;
  logic [ID_W-1:0]     id_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    len_q;
  logic [2:0]          size_q;
  logic [1:0]          burst_q;
  logic                err_q;
  logic [LEN_W-1:0]    beat_q;
  logic [3:0]          lat_cnt;
  logic [DATA_W-1:0]   rdata_q;
  logic [ID_W-1:0]     rid_q;
  logic [1:0]          rresp_q;
  logic                rlast_q;
  logic                rvalid_q;
  logic                mem_cs_q;
  logic [ADDR_W-1:0]   addr_out_q;

  logic                ar_err;
  logic [ADDR_W-1:0]   incr;
  logic [ADDR_W-1:0]   wrap_mask;
  logic [ADDR_W-1:0]   next_addr;

  // Request is answered with SLVERR beats if it cannot be served as asked.
  always_comb begin
    ar_err = 1'b0;
    if (bus.ARBURST == 2'b11) ar_err = 1'b1;
    if (bus.ARSIZE > 3'(MAX_SIZE)) ar_err = 1'b1;
    if (bus.ARBURST == 2'b10 &&
        !(bus.ARLEN == LEN_W'(1) || bus.ARLEN == LEN_W'(3) ||
          bus.ARLEN == LEN_W'(7) || bus.ARLEN == LEN_W'(15)))
      ar_err = 1'b1;
  end

  // WRAP keeps the upper address bits and lets the low bits roll inside the window.
  always_comb begin
    incr      = ADDR_W'(1) << size_q;
    wrap_mask = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);
    case (burst_q)
      2'b00:   next_addr = addr_q;
      2'b10:   next_addr = (addr_q & ~wrap_mask) | ((addr_q + incr) & wrap_mask);
      default: next_addr = addr_q + incr;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESETn) begin
      state      <= S_IDLE;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      err_q      <= 1'b0;
      beat_q     <= '0;
      lat_cnt    <= '0;
      rdata_q    <= '0;
      rid_q      <= '0;
      rresp_q    <= '0;
      rlast_q    <= 1'b0;
      rvalid_q   <= 1'b0;
      mem_cs_q   <= 1'b0;
      addr_out_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.ARVALID && bus.ARREADY) begin
            id_q       <= bus.ARID;
            addr_q     <= bus.ARADDR;
            len_q      <= bus.ARLEN;
            size_q     <= bus.ARSIZE;
            burst_q    <= bus.ARBURST;
            err_q      <= ar_err;
            beat_q     <= '0;
            lat_cnt    <= '0;
            mem_cs_q   <= !ar_err;
            addr_out_q <= bus.ARADDR;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            rdata_q    <= err_q ? '0 : data_in;
            rid_q      <= id_q;
            rresp_q    <= err_q ? 2'b10 : 2'b00;
            rlast_q    <= (beat_q == len_q);
            rvalid_q   <= 1'b1;
            mem_cs_q   <= 1'b0;
            addr_out_q <= '0;
            state      <= S_RESP;
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end
        S_RESP: begin
          if (bus.RREADY) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rdata_q  <= '0;
            rid_q    <= '0;
            rresp_q  <= '0;
            if (rlast_q) begin
              state <= S_IDLE;
            end else begin
              addr_q     <= next_addr;
              addr_out_q <= next_addr;
              mem_cs_q   <= !err_q;
              beat_q     <= beat_q + LEN_W'(1);
              lat_cnt    <= '0;
              state      <= S_WAIT;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ARREADY = (state == S_IDLE) && !ar_block;
  assign bus.RVALID  = rvalid_q;
  assign bus.RDATA   = rdata_q;
  assign bus.RID     = rid_q;
  assign bus.RRESP   = rresp_q;
  assign bus.RLAST   = rlast_q;
  assign mem_cs      = mem_cs_q;
  assign address_out = addr_out_q;
  assign dbg_state   = state;
endmodule

// File: doc/slave_read_mem_burst.md
SLAVE_READ_MEM_BURST -- requirements
Module: slave_read_mem_burst

Interface
REQ-001 Parameter ID_W, default 4, AXI ID width.
REQ-002 Parameter ADDR_W, default 32, byte address width.
REQ-003 Parameter DATA_W, default 32, data width (power of two, 8..128).
REQ-004 Parameter LEN_W, default 4, ARLEN width.
REQ-005 Parameter MEM_LAT, default 2, cycles from address_out stable to data_in valid (range 1..15).
REQ-006 One clock; reset is synchronous and active-high; ports ACLK (clock) and ARESETn (reset, active-high despite the name).
REQ-007 ACLK  in  1  clock.
REQ-008 ARESETn  in  1  synchronous active-high reset.
REQ-009 ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  ID_W/ADDR_W/LEN_W/3/2  read address channel.
REQ-010 ARVALID in 1, ARREADY out 1  address handshake.
REQ-011 RID/RDATA/RRESP/RLAST/RVALID  out  ID_W/DATA_W/2/1/1  read data channel; RREADY in 1.
REQ-012 ar_block  in  1  when high, ARREADY is forced low (arbiter hold-off).
REQ-013 mem_cs  out  1  memory read enable; address_out  out  ADDR_W  byte address; data_in  in  DATA_W  memory data.

Function
REQ-014 States: IDLE, WAIT, RESP; encoding is free.
REQ-015 IDLE: ARREADY = !ar_block; all other outputs 0.
REQ-016 ARVALID&&ARREADY in IDLE: latch ID, ADDR, LEN, SIZE, BURST; clear beat count; -> WAIT.
REQ-017 WAIT lasts exactly MEM_LAT cycles: mem_cs=1, address_out = current beat address, held stable; ARREADY=0.
REQ-018 Last WAIT cycle: data_in registered into RDATA register (forced to 0 if error burst); -> RESP.
REQ-019 RESP: RVALID=1; RDATA, RID, RRESP, RLAST come from registers and stay stable until RREADY.
REQ-020 RLAST=1 only on beat index == latched LEN.
REQ-021 RESP&&RREADY: last beat -> IDLE; else advance address, increment beat count, -> WAIT.
REQ-022 First-beat latency: AR handshake at edge of cycle 0 -> RVALID first high in cycle MEM_LAT+1; each later beat has RVALID high MEM_LAT+1 cycles after the previous beat's handshake.
REQ-023 Beat increment = 1<<SIZE bytes.
REQ-024 FIXED (2'b00): address constant.
REQ-025 INCR (2'b01): address += increment, modulo 2^ADDR_W (no 4 KB check).
REQ-026 WRAP (2'b10): wrap bytes W=(LEN+1)<<SIZE; next = (addr & ~(W-1)) | ((addr+incr) & (W-1)).
REQ-027 Error burst (any of): BURST==2'b11; SIZE > log2(DATA_W/8); WRAP with LEN not in {1,3,7,15}.
REQ-028 Error burst: still returns LEN+1 beats; RRESP=2'b10 (SLVERR), RDATA=0, mem_cs=0 in WAIT; WAIT timing unchanged.
REQ-029 Normal burst: RRESP=2'b00.
REQ-030 ar_block rising during a burst has no effect on that burst.
REQ-031 RREADY held high: no extra bubbles beyond REQ-022.
REQ-032 RREADY low in RESP: remain in RESP indefinitely, outputs unchanged.

Reset
REQ-033 ARESETn high at any clock edge: state->IDLE and all latched fields, counters and RDATA register -> 0, regardless of state.
REQ-034 Outputs in the cycle after reset: ARREADY=!ar_block; RVALID, RLAST, mem_cs=0; RID, RDATA, RRESP, address_out=0.
REQ-035 Mid-burst reset: burst discarded; no further beats.

Verification
REQ-036 MEM_LAT=2, INCR, ARADDR=0x100, LEN=3, SIZE=2, RREADY=1 -> address_out 0x100,0x104,0x108,0x10C; RVALID cycles 3,6,9,12; RLAST only in cycle 12; RRESP=0.
REQ-037 WRAP, ARADDR=0x1C, LEN=3, SIZE=2 -> address_out 0x1C,0x10,0x14,0x18.
REQ-038 FIXED, ARADDR=0x40, LEN=2 -> address_out 0x40 on all 3 beats; RLAST on beat 3.
REQ-039 ARSIZE=3 with DATA_W=32, LEN=1 -> 2 beats; RRESP=2'b10; RDATA=0; mem_cs never high.
REQ-040 RREADY low for 5 cycles on beat 0 -> RVALID and RDATA held constant; next address issued only after the handshake.
REQ-041 Reset asserted in WAIT of beat 2 -> next cycle RVALID=0, mem_cs=0; ARREADY=1 (ar_block=0); ar_block=1 in IDLE -> ARREADY=0.
